// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 hazard padder: opcode constants,
// instruction field positions, the default padding word and the FSM state.
package mips32_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // OR R0,R0,R0
  localparam logic [31:0] NOP_WORD_DEF = 32'h0c000000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    FULL = 2'd2
  } state_t;

  function automatic logic is_hlt(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB] == OP_HLT;
  endfunction

endpackage

// File: rtl/mips32_reg_decode.sv
// Combinational register-usage decoder.
// Ports:
//   instr            instruction word to decode
//   dst, dst_vld     destination register and whether it is written
//   src1, src1_vld   first source register (rs) and whether it is read
//   src2, src2_vld   second source register (rt) and whether it is read
// R0 is never reported as a valid destination or source.
module mips32_reg_decode
  import mips32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  dst,
  output logic        dst_vld,
  output logic [4:0]  src1,
  output logic        src1_vld,
  output logic [4:0]  src2,
  output logic        src2_vld
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_lsbs;

  assign op = instr[OP_MSB:OP_LSB];
  assign rs = instr[RS_MSB:RS_LSB];
  assign rt = instr[RT_MSB:RT_LSB];
  assign rd = instr[RD_MSB:RD_LSB];
  assign unused_lsbs = ^instr[RD_LSB-1:0];

  always_comb begin
    dst      = rd;
    dst_vld  = 1'b0;
    src1     = rs;
    src1_vld = 1'b0;
    src2     = rt;
    src2_vld = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        dst      = rd;
        dst_vld  = 1'b1;
        src1_vld = 1'b1;
        src2_vld = 1'b1;
      end
      OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: begin
        dst      = rt;
        dst_vld  = 1'b1;
        src1_vld = 1'b1;
      end
      OP_SW: begin
        src1_vld = 1'b1;
        src2_vld = 1'b1;
      end
      OP_BNEQZ, OP_BEQZ: begin
        src1_vld = 1'b1;
      end
      default: ;
    endcase
    if (dst == 5'd0)  dst_vld  = 1'b0;
    if (src1 == 5'd0) src1_vld = 1'b0;
    if (src2 == 5'd0) src2_vld = 1'b0;
  end

endmodule

// File: rtl/mips32_hazard_padder.sv
// Inserts NOP padding between register producers and consumers so that at
// least NOP_GAP words separate them, and assigns each emitted word an
// instruction-memory address.
// Ports:
//   clk1, rst_n             clock, async active-low reset
//   in_valid/in_instr       upstream instruction stream
//   in_ready                upstream word accepted this cycle
//   out_valid/out_instr     emitted word (instruction or NOP_WORD)
//   out_addr                word address of out_instr
//   out_ready               downstream consumes the output word
//   out_is_nop              emitted word is padding
//   halted, overflow        HLT emitted / address space exhausted
//   nop_count               saturating count of inserted NOPs
//
// state | meaning
// RUN   | accepting input and emitting words
// HALT  | HLT loaded into the output register; no more input
// FULL  | word for address 1023 loaded without HLT; no more input
module mips32_hazard_padder
  import mips32_pkg::*;
#(
  parameter int          NOP_GAP  = 1,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [9:0]  out_addr,
  input  logic        out_ready,
  output logic        out_is_nop,
  output logic        halted,
  output logic        overflow,
  output logic [15:0] nop_count
);

  state_t             state;
  logic [4:0]         hist_reg [NOP_GAP];
  logic [NOP_GAP-1:0] hist_vld;

  logic [4:0] dst;
  logic       dst_vld;
  logic [4:0] src1;
  logic       src1_vld;
  logic [4:0] src2;
  logic       src2_vld;

  logic       hazard;
  logic       free;
  logic       can_load;
  logic       push_vld;
  logic [9:0] load_addr;

  mips32_reg_decode u_decode (
    .instr    (in_instr),
    .dst      (dst),
    .dst_vld  (dst_vld),
    .src1     (src1),
    .src1_vld (src1_vld),
    .src2     (src2),
    .src2_vld (src2_vld)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NOP_GAP; i++) begin
      if (hist_vld[i] && ((src1_vld && src1 == hist_reg[i]) ||
                          (src2_vld && src2 == hist_reg[i])))
        hazard = 1'b1;
    end
  end

  assign free     = !out_valid || out_ready;
  // rst_n gates in_ready so it reads 0 while reset is held.
  assign in_ready = rst_n && state == RUN && free && !hazard;
  assign can_load = rst_n && state == RUN && free && in_valid;
  // A literal NOP_WORD from upstream never counts as a producer.
  assign push_vld = !hazard && dst_vld && (in_instr != NOP_WORD);
  // Address the new word will occupy: the current word is leaving if valid.
  assign load_addr = out_valid ? out_addr + 10'd1 : out_addr;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_is_nop <= 1'b0;
      out_addr   <= '0;
      nop_count  <= '0;
      halted     <= 1'b0;
      overflow   <= 1'b0;
      hist_vld   <= '0;
      for (int i = 0; i < NOP_GAP; i++) hist_reg[i] <= '0;
    end else begin
      if (out_valid && out_ready) out_addr <= out_addr + 10'd1;

      if (can_load) begin
        out_valid  <= 1'b1;
        out_instr  <= hazard ? NOP_WORD : in_instr;
        out_is_nop <= hazard;

        hist_reg[0] <= dst;
        hist_vld[0] <= push_vld;
        for (int i = 1; i < NOP_GAP; i++) begin
          hist_reg[i] <= hist_reg[i-1];
          hist_vld[i] <= hist_vld[i-1];
        end

        if (hazard && nop_count != 16'hffff) nop_count <= nop_count + 16'd1;

        if (!hazard && is_hlt(in_instr)) begin
          state  <= HALT;
          halted <= 1'b1;
        end else if (load_addr == 10'd1023) begin
          state    <= FULL;
          overflow <= 1'b1;
        end
      end else if (free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips32_hazard_padder.sv
module tb_mips32_hazard_padder;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready,  out_valid,  out_is_nop,  halted,  overflow;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [15:0] nop_count;

  logic        in_ready3, out_valid3, out_is_nop3, halted3, overflow3;
  logic [31:0] out_instr3;
  logic [9:0]  out_addr3;
  logic [15:0] nop_count3;

  localparam logic [31:0] NOP = 32'h0c000000;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic sel = 1'b0;

  logic [31:0] q_instr [$];
  logic [9:0]  q_addr  [$];
  logic        q_nop   [$];
  int          q_cyc   [$];
  logic [31:0] q3_instr[$];
  logic        q3_nop  [$];

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  mips32_hazard_padder #(.NOP_GAP(1)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_addr(out_addr), .out_ready(out_ready), .out_is_nop(out_is_nop),
    .halted(halted), .overflow(overflow), .nop_count(nop_count)
  );

  mips32_hazard_padder #(.NOP_GAP(3)) dut3 (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_instr(out_instr3),
    .out_addr(out_addr3), .out_ready(out_ready), .out_is_nop(out_is_nop3),
    .halted(halted3), .overflow(overflow3), .nop_count(nop_count3)
  );

  // A word seen valid+ready at the negedge is consumed at the next posedge.
  always @(negedge clk1) begin
    if (rst_n && out_valid && out_ready) begin
      q_instr.push_back(out_instr);
      q_addr.push_back(out_addr);
      q_nop.push_back(out_is_nop);
      q_cyc.push_back(cyc);
    end
    if (rst_n && out_valid3 && out_ready) begin
      q3_instr.push_back(out_instr3);
      q3_nop.push_back(out_is_nop3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    q_instr.delete(); q_addr.delete(); q_nop.delete(); q_cyc.delete();
    q3_instr.delete(); q3_nop.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    clear_logs();
  endtask

  // Call at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic feed(input logic [31:0] w, output int t);
    in_valid = 1'b1; in_instr = w; t = 0;
    @(negedge clk1);
    while (!(sel ? in_ready3 : in_ready) && t < 50) begin
      @(negedge clk1);
      t++;
    end
    chk("feed_timeout", 32'(t < 50), 32'd1);
    @(posedge clk1); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_halt();
    int t = 0;
    while (!halted && t < 100) begin
      @(posedge clk1); #1;
      t++;
    end
    chk("halt_timeout", 32'(halted), 32'd1);
    repeat (2) @(posedge clk1);
    #1;
  endtask

  logic [31:0] e1 [8];
  logic        n1 [8];
  logic [31:0] s1 [5];
  logic [31:0] s2 [3];
  logic [31:0] s4 [5];
  logic        en3 [5];
  logic [31:0] e3  [5];

  initial begin
    int t;
    int n;
    e1 = '{32'h28010078, NOP, 32'h20220000, NOP, 32'h2842002d, NOP, 32'h24220001, 32'hfc000000};
    n1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    s1 = '{32'h28010078, 32'h20220000, 32'h2842002d, 32'h24220001, 32'hfc000000};
    s2 = '{32'h28010078, 32'h28420005, 32'hfc000000};
    s4 = '{32'h28010078, 32'h28420005, 32'h28630003, 32'h28840004, 32'hfc000000};
    e3 = '{32'h28010078, NOP, NOP, NOP, 32'h20220000};
    en3 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr",  32'(out_addr),  32'd0);
    chk("rst_nop_count", 32'(nop_count), 32'd0);
    chk("rst_halted",    32'(halted),    32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);

    // Hazard stream, gap 1
    sel = 1'b0;
    do_reset();
    @(posedge clk1); #1;
    for (int i = 0; i < 5; i++) feed(s1[i], t);
    wait_halt();
    chk("t1_count", q_instr.size(), 32'd8);
    for (int i = 0; i < 8 && i < q_instr.size(); i++) begin
      chk("t1_instr", q_instr[i], e1[i]);
      chk("t1_addr",  32'(q_addr[i]), 32'(i));
      chk("t1_is_nop", 32'(q_nop[i]), 32'(n1[i]));
    end
    chk("t1_nop_count", 32'(nop_count), 32'd3);
    chk("t1_halted",    32'(halted),    32'd1);
    chk("t1_in_ready",  32'(in_ready),  32'd0);
    chk("t1_drained",   32'(out_valid), 32'd0);

    // Independent stream: no NOPs, one word per cycle
    do_reset();
    @(posedge clk1); #1;
    for (int i = 0; i < 3; i++) begin
      feed(s2[i], t);
      chk("t2_in_ready_wait", 32'(t), 32'd0);
    end
    wait_halt();
    chk("t2_count", q_instr.size(), 32'd3);
    for (int i = 0; i < 3 && i < q_instr.size(); i++) begin
      chk("t2_instr", q_instr[i], s2[i]);
      chk("t2_is_nop", 32'(q_nop[i]), 32'd0);
      if (i > 0) chk("t2_rate", 32'(q_cyc[i] - q_cyc[i-1]), 32'd1);
    end
    chk("t2_nop_count", 32'(nop_count), 32'd0);

    // Gap 3 instance
    sel = 1'b1;
    do_reset();
    @(posedge clk1); #1;
    feed(32'h28010078, t);
    feed(32'h20220000, t);
    repeat (3) @(posedge clk1);
    #1;
    chk("t3_count", q3_instr.size(), 32'd5);
    for (int i = 0; i < 5 && i < q3_instr.size(); i++) begin
      chk("t3_instr", q3_instr[i], e3[i]);
      chk("t3_is_nop", 32'(q3_nop[i]), 32'(en3[i]));
    end
    chk("t3_nop_count", 32'(nop_count3), 32'd3);
    sel = 1'b0;

    // Downstream stall for 5 cycles
    do_reset();
    @(posedge clk1); #1;
    fork
      begin
        for (int i = 0; i < 5; i++) feed(s4[i], t);
      end
      begin
        @(posedge clk1);
        @(posedge clk1); #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk1);
          chk("t4_stall_valid", 32'(out_valid), 32'd1);
          chk("t4_stall_instr", out_instr, 32'h28420005);
          chk("t4_stall_addr",  32'(out_addr), 32'd1);
          chk("t4_stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk1); #1;
        out_ready = 1'b1;
      end
    join
    wait_halt();
    chk("t4_count", q_instr.size(), 32'd5);
    for (int i = 0; i < 5 && i < q_instr.size(); i++) begin
      chk("t4_instr", q_instr[i], s4[i]);
      chk("t4_addr",  32'(q_addr[i]), 32'(i));
    end

    // Asynchronous reset mid-stream
    do_reset();
    @(posedge clk1); #1;
    in_instr = 32'h28210001;
    in_valid = 1'b1;
    repeat (4) @(posedge clk1);
    #3;
    chk("t5_pre_nop_count", 32'(nop_count), 32'd2);
    chk("t5_pre_addr",      32'(out_addr),  32'd3);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid",  32'(out_valid),  32'd0);
    chk("t5_out_instr",  out_instr,       32'd0);
    chk("t5_out_is_nop", 32'(out_is_nop), 32'd0);
    chk("t5_out_addr",   32'(out_addr),   32'd0);
    chk("t5_nop_count",  32'(nop_count),  32'd0);
    chk("t5_halted",     32'(halted),     32'd0);
    chk("t5_overflow",   32'(overflow),   32'd0);
    chk("t5_in_ready",   32'(in_ready),   32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk1);
    #1;
    in_valid = 1'b0;
    chk("t5_restart_count", 32'(q_instr.size() >= 2), 32'd1);
    if (q_instr.size() >= 2) begin
      chk("t5_restart_addr0",  32'(q_addr[0]), 32'd0);
      chk("t5_restart_instr0", q_instr[0], 32'h28210001);
      chk("t5_restart_addr1",  32'(q_addr[1]), 32'd1);
      chk("t5_restart_nop1",   32'(q_nop[1]), 32'd1);
    end

    // Address space exhaustion
    do_reset();
    in_instr = 32'h28010078;
    in_valid = 1'b1;
    n = 0;
    while (!overflow && n < 1100) begin
      @(posedge clk1);
      n++;
      #1;
    end
    chk("t6_cycles",   32'(n),        32'd1024);
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk1);
    #1;
    chk("t6_count",      q_instr.size(), 32'd1024);
    if (q_instr.size() > 0)
      chk("t6_last_addr", 32'(q_addr[q_addr.size()-1]), 32'd1023);
    chk("t6_overflow",   32'(overflow),  32'd1);
    chk("t6_halted",     32'(halted),    32'd0);
    chk("t6_out_valid",  32'(out_valid), 32'd0);
    chk("t6_in_ready_hold", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
